// File: rtl/vector_out_streamer_if.sv
// rtl/vector_out_streamer_if.sv - lane stream handshake between the vector output streamer and its consumer
interface vector_out_streamer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] laneData;
    logic [2:0]            laneIndex;
    logic                  laneValid;
    logic                  laneLast;
    logic                  laneReady;

    modport master (
        output laneData,
        output laneIndex,
        output laneValid,
        output laneLast,
        input  laneReady
    );

    modport slave (
        input  laneData,
        input  laneIndex,
        input  laneValid,
        input  laneLast,
        output laneReady
    );
endinterface

// File: rtl/vector_out_streamer.sv
// rtl/vector_out_streamer.sv - buffers flagged WB vectors and streams them one lane per beat
module vector_out_streamer #(
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int PTR_WIDTH   = 2,
    parameter int SKID        = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              outFlag,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] out,
    vector_out_streamer_if.master             lane,
    output logic                              stallRequest,
    output logic                              overflow,
    input  logic                              clearOverflow,
    output logic                              busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [PTR_WIDTH:0] FULL_COUNT  = (PTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0] STALL_LEVEL = (PTR_WIDTH + 1)'(FIFO_DEPTH - SKID);
    localparam logic [2:0]         LAST_INDEX  = 3'(VECTOR_SIZE - 1);

    logic [DATA_WIDTH*VECTOR_SIZE-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] shiftReg;
    logic [PTR_WIDTH-1:0]              wrPtr;
    logic [PTR_WIDTH-1:0]              rdPtr;
    logic [PTR_WIDTH:0]                count;
    logic [0:0]                        state;
    logic [2:0]                        laneIndexReg;

    logic full;
    logic push;
    logic drop;
    logic laneAccept;
    logic atLast;
    logic pop;

    // Fullness and pop eligibility both use the count at the start of the cycle,
    // so a same-cycle pop never makes room and a same-cycle push is never popped.
    always_comb begin
        full       = (count == FULL_COUNT);
        push       = outFlag && !full;
        drop       = outFlag && full;
        laneAccept = (state == SEND) && lane.laneReady;
        atLast     = (laneIndexReg == LAST_INDEX);
        pop        = (count != '0) && ((state == IDLE) || (laneAccept && atLast));
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            state        <= IDLE;
            laneIndexReg <= 3'd0;
            shiftReg     <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_WIDTH + 1)'(1);
                2'b01:   count <= count - (PTR_WIDTH + 1)'(1);
                default: count <= count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end

            // Shifting on every accepted beat leaves the register all-zero once a
            // vector has fully drained, so laneData reads 0 while idle.
            if (pop) begin
                shiftReg     <= mem[rdPtr];
                laneIndexReg <= 3'd0;
                state        <= SEND;
            end else if (laneAccept) begin
                shiftReg <= shiftReg >> DATA_WIDTH;
                if (atLast) begin
                    laneIndexReg <= 3'd0;
                    state        <= IDLE;
                end else begin
                    laneIndexReg <= laneIndexReg + 3'd1;
                end
            end
        end
    end

    assign lane.laneData  = shiftReg[DATA_WIDTH-1:0];
    assign lane.laneIndex = laneIndexReg;
    assign lane.laneValid = (state == SEND);
    assign lane.laneLast  = (state == SEND) && atLast;
    assign stallRequest   = (count >= STALL_LEVEL);
    assign busy           = (count != '0) || (state == SEND);
endmodule
